// File: rtl/mole_spawner.sv
// Mole bitmap generator: LFSR-chosen hole with linear probing, per-hole lifetime
// countdown, and whack/expiry resolution into one-cycle hit and miss masks.
module mole_spawner #(
    parameter int          NUM_HOLES  = 5,
    parameter int          MAX_ACTIVE = 2,
    parameter int          LIFE_W     = 8,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           spawn_req,
    input  logic [LIFE_W-1:0]              lifetime,
    input  logic                           tick_en,
    input  logic [NUM_HOLES-1:0]           whack,
    output logic [NUM_HOLES-1:0]           moles,
    output logic [$clog2(NUM_HOLES+1)-1:0] active_count,
    output logic                           busy,
    output logic                           spawn_done,
    output logic [$clog2(NUM_HOLES)-1:0]   spawn_idx,
    output logic                           spawn_fail,
    output logic [NUM_HOLES-1:0]           hit_mask,
    output logic [NUM_HOLES-1:0]           miss_mask
);
    localparam int IW = $clog2(NUM_HOLES);
    localparam int CW = $clog2(NUM_HOLES + 1);

    localparam logic [15:0]       SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_HOLES - 1);
    localparam logic [CW-1:0]     MAX_CNT  = CW'(MAX_ACTIVE);
    localparam logic [LIFE_W-1:0] LIFE_ONE = LIFE_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [IW-1:0] lfsr_to_hole(input logic [15:0] l);
        return IW'(l % 16'(NUM_HOLES));
    endfunction

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] c);
        return (c == LAST_IDX) ? '0 : c + 1'b1;
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [NUM_HOLES-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [LIFE_W-1:0] clamp_life(input logic [LIFE_W-1:0] lt);
        return (lt == '0) ? LIFE_ONE : lt;
    endfunction

    state_t                state_q, state_d;
    logic [15:0]           lfsr;
    logic [IW-1:0]         cand_q, cand_d;
    logic [IW-1:0]         probes_q, probes_d;
    logic [LIFE_W-1:0]     life_q [NUM_HOLES];

    logic                  place;
    logic                  fail_d;
    logic [NUM_HOLES-1:0]  grant_vec;
    logic [NUM_HOLES-1:0]  hit_vec;
    logic [NUM_HOLES-1:0]  expire_vec;
    logic [NUM_HOLES-1:0]  moles_d;

    assign active_count = popcount(moles);
    assign busy         = (state_q != IDLE);

    // Per-hole event resolution: a whack outranks an expiry on the same hole.
    always_comb begin
        hit_vec    = whack & moles;
        expire_vec = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (moles[i] && tick_en && (life_q[i] == LIFE_ONE) && !hit_vec[i]) begin
                expire_vec[i] = 1'b1;
            end
        end
    end

    // Placement FSM works on the pre-clear bitmap, so a hole freed this cycle
    // is never granted in the same cycle.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        probes_d  = probes_q;
        place     = 1'b0;
        fail_d    = 1'b0;
        grant_vec = '0;
        case (state_q)
            IDLE: begin
                if (spawn_req) begin
                    if (active_count < MAX_CNT) begin
                        cand_d   = lfsr_to_hole(lfsr);
                        probes_d = '0;
                        state_d  = PROBE;
                    end else begin
                        fail_d = 1'b1;
                    end
                end
            end
            PROBE: begin
                if (!moles[cand_q]) begin
                    place   = 1'b1;
                    state_d = IDLE;
                end else if (probes_q < LAST_IDX) begin
                    cand_d   = wrap_inc(cand_q);
                    probes_d = probes_q + 1'b1;
                end else begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        grant_vec[cand_q] = place;
        moles_d = (moles & ~hit_vec & ~expire_vec) | grant_vec;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr       <= SEED_EFF;
            state_q    <= IDLE;
            cand_q     <= '0;
            probes_q   <= '0;
            moles      <= '0;
            spawn_idx  <= '0;
            spawn_done <= 1'b0;
            spawn_fail <= 1'b0;
            hit_mask   <= '0;
            miss_mask  <= '0;
        end else begin
            lfsr       <= lfsr_next(lfsr);
            state_q    <= state_d;
            cand_q     <= cand_d;
            probes_q   <= probes_d;
            moles      <= moles_d;
            spawn_done <= place;
            spawn_fail <= fail_d;
            hit_mask   <= hit_vec;
            miss_mask  <= expire_vec;
            if (place) begin
                spawn_idx <= cand_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (!reset) begin
                life_q[i] <= '0;
            end else if (grant_vec[i]) begin
                life_q[i] <= clamp_life(lifetime);
            end else if (hit_vec[i] || expire_vec[i]) begin
                life_q[i] <= '0;
            end else if (moles[i] && tick_en && (life_q[i] > LIFE_ONE)) begin
                life_q[i] <= life_q[i] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// Scoreboard bench for mole_spawner: two instances (MAX_ACTIVE 5 and 2) share a clock;
// sel chooses which one the stimulus and the observed outputs refer to.
module tb_mole_spawner;
    localparam int NH = 5;
    localparam int LW = 8;
    localparam int CW = $clog2(NH + 1);
    localparam int IW = $clog2(NH);

    typedef struct {
        bit            fail;
        int            idx;
        int            cycles;
        logic [NH-1:0] moles;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          spawn_req = 1'b0;
    logic [LW-1:0] lifetime = '0;
    logic          tick_en = 1'b0;
    logic [NH-1:0] whack = '0;
    bit            sel = 1'b0;

    logic [NH-1:0] moles_a, hit_mask_a, miss_mask_a, moles_b, hit_mask_b, miss_mask_b;
    logic [CW-1:0] active_count_a, active_count_b;
    logic [IW-1:0] spawn_idx_a, spawn_idx_b;
    logic          busy_a, spawn_done_a, spawn_fail_a, busy_b, spawn_done_b, spawn_fail_b;

    logic [NH-1:0] moles_o, hit_mask_o, miss_mask_o;
    logic [CW-1:0] active_count_o;
    logic [IW-1:0] spawn_idx_o;
    logic          busy_o, spawn_done_o, spawn_fail_o;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    logic [NH-1:0] exp_a, exp_b;
    logic [15:0]   m_lfsr;
    int            last_idx;
    int            h;

    always #5 clock = ~clock;

    mole_spawner #(.NUM_HOLES(NH), .MAX_ACTIVE(5), .LIFE_W(LW), .SEED(16'hACE1)) dut_a (
        .clock(clock), .reset(reset), .spawn_req(spawn_req & ~sel), .lifetime(lifetime),
        .tick_en(tick_en & ~sel), .whack(whack & {NH{~sel}}), .moles(moles_a),
        .active_count(active_count_a), .busy(busy_a), .spawn_done(spawn_done_a),
        .spawn_idx(spawn_idx_a), .spawn_fail(spawn_fail_a), .hit_mask(hit_mask_a),
        .miss_mask(miss_mask_a)
    );

    mole_spawner #(.NUM_HOLES(NH), .MAX_ACTIVE(2), .LIFE_W(LW), .SEED(16'hACE1)) dut_b (
        .clock(clock), .reset(reset), .spawn_req(spawn_req & sel), .lifetime(lifetime),
        .tick_en(tick_en & sel), .whack(whack & {NH{sel}}), .moles(moles_b),
        .active_count(active_count_b), .busy(busy_b), .spawn_done(spawn_done_b),
        .spawn_idx(spawn_idx_b), .spawn_fail(spawn_fail_b), .hit_mask(hit_mask_b),
        .miss_mask(miss_mask_b)
    );

    assign moles_o        = sel ? moles_b        : moles_a;
    assign hit_mask_o     = sel ? hit_mask_b     : hit_mask_a;
    assign miss_mask_o    = sel ? miss_mask_b    : miss_mask_a;
    assign active_count_o = sel ? active_count_b : active_count_a;
    assign spawn_idx_o    = sel ? spawn_idx_b    : spawn_idx_a;
    assign busy_o         = sel ? busy_b         : busy_a;
    assign spawn_done_o   = sel ? spawn_done_b   : spawn_done_a;
    assign spawn_fail_o   = sel ? spawn_fail_b   : spawn_fail_a;

    // Reference LFSR: 16-bit Fibonacci, taps 15/13/12/10, seeded on reset.
    always @(posedge clock) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Expected outcome of a request: capacity reject, or linear probe from lfsr%NH.
    function automatic exp_t predict(input logic [NH-1:0] m, input int maxa, input logic [15:0] l);
        exp_t e;
        int   start;
        e.fail   = 1'b1;
        e.idx    = -1;
        e.moles  = m;
        start    = int'(l % NH);
        if ($countones(m) >= maxa) begin
            e.cycles = 1;
            return e;
        end
        e.cycles = NH + 1;
        for (int k = 0; k < NH; k++) begin
            int hole;
            hole = (start + k) % NH;
            if (!m[hole]) begin
                e.fail   = 1'b0;
                e.idx    = hole;
                e.cycles = k + 2;
                e.moles  = m | (NH'(1) << hole);
                break;
            end
        end
        return e;
    endfunction

    task automatic do_spawn(input int want, input logic [LW-1:0] lt, input bit wg);
        exp_t e, ev;
        int   n, c;
        bit   seen;
        n = 0;
        while (want >= 0 && int'(m_lfsr % NH) != want && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (want >= 0) check("lfsr_wait", int'(m_lfsr % NH), want);
        lifetime = lt;
        e = predict(sel ? exp_b : exp_a, sel ? 2 : 5, m_lfsr);
        sb.push_back(e);
        spawn_req = 1'b1;
        @(negedge clock);
        spawn_req = 1'b0;
        c = 1;
        seen = 1'b0;
        while (!seen && c <= NH + 3) begin
            whack = '0;
            if (spawn_done_o || spawn_fail_o) begin
                seen = 1'b1;
                ev = sb.pop_front();
                check("spawn_done", spawn_done_o, !ev.fail);
                check("spawn_fail", spawn_fail_o, ev.fail);
                check("latency", c, ev.cycles);
                check("moles", moles_o, ev.moles);
                check("busy_end", busy_o, 0);
                if (!ev.fail) check("spawn_idx", spawn_idx_o, ev.idx);
                if (wg) check("hit_at_grant", hit_mask_o, 0);
                if (sel) exp_b = ev.moles;
                else     exp_a = ev.moles;
                last_idx = ev.idx;
            end else begin
                check("probe_busy", busy_o, 1);
                if (wg && c == sb[0].cycles - 1) whack = NH'(1) << sb[0].idx;
                @(negedge clock);
                c++;
            end
        end
        check("spawn_seen", seen, 1);
        if (!seen) ev = sb.pop_front();
        @(negedge clock);
        check("pulse_one", {spawn_done_o, spawn_fail_o}, 0);
    endtask

    task automatic pulse(input logic [NH-1:0] w, input bit t, input logic [NH-1:0] eh,
                         input logic [NH-1:0] em, input string tag);
        whack = w;
        tick_en = t;
        @(negedge clock);
        whack = '0;
        tick_en = 1'b0;
        exp_a = exp_a & ~eh & ~em;
        check({tag, "_hit"}, hit_mask_o, eh);
        check({tag, "_miss"}, miss_mask_o, em);
        check({tag, "_moles"}, moles_o, exp_a);
        @(negedge clock);
        check({tag, "_clr"}, {hit_mask_o, miss_mask_o}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_moles", moles_a, 0);
        check("rst_count", active_count_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_pulses", {spawn_done_a, spawn_fail_a, hit_mask_a, miss_mask_a}, 0);
        check("rst_idx", spawn_idx_a, 0);
        check("rst_lfsr", dut_a.lfsr, 16'hACE1);
        reset = 1'b1;
        @(negedge clock);
        check("lfsr_step", dut_a.lfsr, 16'h59C3);
        check("lfsr_model", dut_a.lfsr, m_lfsr);
        exp_a = '0;
        exp_b = '0;

        // Capacity reject on the MAX_ACTIVE=2 instance
        sel = 1'b1;
        do_spawn(-1, 8'd200, 1'b0);
        do_spawn(-1, 8'd200, 1'b0);
        check("cap_count", active_count_o, 2);
        do_spawn(-1, 8'd200, 1'b0);
        check("cap_moles_kept", moles_o, exp_b);
        sel = 1'b0;

        do_spawn(2, 8'd200, 1'b0);
        check("basic_moles", moles_o, 5'b00100);
        pulse(5'b00100, 1'b0, 5'b00100, 5'b00000, "whack_hit");
        pulse(5'b01000, 1'b0, 5'b00000, 5'b00000, "whack_empty");

        // Probe wrap from hole 4 to hole 0, with a whack on the hole being granted
        do_spawn(4, 8'd200, 1'b0);
        do_spawn(4, 8'd200, 1'b1);
        check("wrap_moles", moles_o, 5'b10001);

        repeat (3) do_spawn(-1, 8'd200, 1'b0);
        check("full_count", active_count_o, 5);
        do_spawn(-1, 8'd200, 1'b0);
        check("full_moles_kept", moles_o, 5'b11111);
        pulse(5'b11111, 1'b0, 5'b11111, 5'b00000, "whack_all");

        do_spawn(-1, 8'd3, 1'b0);
        h = last_idx;
        for (int t = 1; t <= 3; t++) begin
            repeat (2) @(negedge clock);
            pulse('0, 1'b1, '0, (t == 3) ? (NH'(1) << h) : '0, "life3_tick");
        end

        do_spawn(-1, 8'd0, 1'b0);
        h = last_idx;
        pulse('0, 1'b1, '0, NH'(1) << h, "life0_tick");

        do_spawn(-1, 8'd1, 1'b0);
        h = last_idx;
        pulse(NH'(1) << h, 1'b1, NH'(1) << h, '0, "whack_vs_expire");

        // Reset asserted while the FSM is probing
        do_spawn(-1, 8'd200, 1'b0);
        check("pre_rst_count", active_count_o, 1);
        spawn_req = 1'b1;
        @(negedge clock);
        spawn_req = 1'b0;
        check("mid_probe_busy", busy_o, 1);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_moles", moles_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", spawn_done_o, 0);
        check("mid_rst_lfsr", dut_a.lfsr, 16'hACE1);
        reset = 1'b1;
        exp_a = '0;
        exp_b = '0;
        @(negedge clock);
        check("post_rst_pulses", {spawn_done_o, spawn_fail_o, hit_mask_o, miss_mask_o}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
